// File: rtl/tpg_source.sv
// Traffic pattern generator at a router injection port.
// Emits numbered flits {src, dst, id, seq} over valid/ready until
// NUM_PACKETS flits are accepted, then raises a sticky done flag.
// Every output is driven from a flop, so ready_in and enable never
// reach an output combinationally.
module tpg_source #(
  parameter int         WIDTH        = 32,
  parameter int         N            = 16,
  parameter int         N_ADDR_WIDTH = $clog2(N),
  parameter logic [7:0] ID           = 8'd0,
  parameter int         NODE         = 0,
  parameter int         DEST         = 15,
  parameter int         MODE         = 0,
  parameter int         NUM_PACKETS  = 1002,
  parameter int         GAP          = 0,
  localparam int        DW           = WIDTH - 2*N_ADDR_WIDTH - 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic             done,
  output logic [DW-1:0]    sent_count
);

  localparam int AW = N_ADDR_WIDTH;
  localparam logic [AW-1:0] NODE_A    = AW'(NODE);
  localparam logic [AW-1:0] DEST_INIT = AW'(DEST % N);
  localparam logic [AW-1:0] LAST_A    = AW'(N - 1);
  localparam logic [DW-1:0] NUM_P     = DW'(NUM_PACKETS);

  // The sequence field must be able to hold every packet number.
  if (NUM_PACKETS < 0 || (DW < 31 && NUM_PACKETS >= (1 << DW))) begin : g_num_check
    $error("tpg_source: NUM_PACKETS does not fit in the sequence field");
  end

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic            r_valid;
  logic            r_done;
  logic [WIDTH-1:0] r_data;
  logic [DW-1:0]   r_cnt;
  logic [AW-1:0]   r_dst;
  logic [31:0]     r_gap_cnt;

  logic            w_accept;
  logic            w_last;
  logic [DW-1:0]   w_cnt_inc;
  logic [DW-1:0]   w_cnt_nxt;
  logic [AW-1:0]   w_step1;
  logic [AW-1:0]   w_step2;
  logic [AW-1:0]   w_dst_adv;
  logic [AW-1:0]   w_dst_nxt;
  logic [31:0]     w_gap_nxt;
  logic            w_valid_nxt;
  logic            w_done_nxt;

  // Increment with explicit wrap so non-power-of-two node counts work.
  function automatic logic [AW-1:0] f_wrap_inc(input logic [AW-1:0] d);
    if (d == LAST_A) return '0;
    return d + AW'(1);
  endfunction

  // Handshake and counter helpers shared by the FSM and the datapath.
  always_comb begin
    w_accept  = r_valid & ready_in;
    w_cnt_inc = r_cnt + DW'(1);
    w_last    = (w_cnt_inc == NUM_P);
    w_step1   = f_wrap_inc(r_dst);
    w_step2   = f_wrap_inc(w_step1);
    if (MODE == 0) w_dst_adv = r_dst;
    else           w_dst_adv = (w_step1 == NODE_A) ? w_step2 : w_step1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  // Next-state logic: run/pause, gap timing and completion.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (enable) w_next_state = (r_cnt < NUM_P) ? S_SEND : S_DONE;
      end
      S_SEND: begin
        if (w_accept) begin
          if (w_last)       w_next_state = S_DONE;
          else if (GAP > 0) w_next_state = S_GAP;
          else if (!enable) w_next_state = S_IDLE;
          else              w_next_state = S_SEND;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == 32'd0) w_next_state = enable ? S_SEND : S_IDLE;
      end
      S_DONE:  w_next_state = S_DONE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output/next-value logic, registered below so outputs come from flops.
  always_comb begin
    w_valid_nxt = (w_next_state == S_SEND);
    w_done_nxt  = (w_next_state == S_DONE);
    w_cnt_nxt   = w_accept ? w_cnt_inc : r_cnt;
    w_dst_nxt   = w_accept ? w_dst_adv : r_dst;
    w_gap_nxt   = r_gap_cnt;
    if (r_state == S_SEND && w_next_state == S_GAP)
      w_gap_nxt = 32'(GAP - 1);
    else if (r_state == S_GAP && r_gap_cnt != 32'd0)
      w_gap_nxt = r_gap_cnt - 32'd1;
  end

  // Datapath registers; the flit is reloaded with unchanged fields while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_data    <= '0;
      r_cnt     <= '0;
      r_dst     <= DEST_INIT;
      r_gap_cnt <= '0;
    end else begin
      r_valid   <= w_valid_nxt;
      r_done    <= w_done_nxt;
      r_cnt     <= w_cnt_nxt;
      r_dst     <= w_dst_nxt;
      r_gap_cnt <= w_gap_nxt;
      if (w_valid_nxt) r_data <= {NODE_A, w_dst_nxt, ID, w_cnt_nxt};
    end
  end

  assign data_out   = r_data;
  assign valid_out  = r_valid;
  assign done       = r_done;
  assign sent_count = r_cnt;

endmodule

// File: tb/tb_tpg_source.sv
// Directed bench for tpg_source: four instances cover the default
// stream, gap timing, rotating destinations and an empty packet budget.
module tb_tpg_source;

  logic clk;
  logic rst;
  logic enA, rdyA, validA, doneA;
  logic enB, rdyB, validB, doneB;
  logic enC, rdyC, validC, doneC;
  logic enD, rdyD, validD, doneD;
  logic [31:0] dataA, dataB, dataC, dataD;
  logic [15:0] cntA, cntB, cntC, cntD;

  int totalChecks = 0;
  int badChecks   = 0;
  int expSeq;
  logic hold;
  logic [12:0] patB;
  int dstTab [20];

  tpg_source #(.ID(8'd5), .NODE(3), .DEST(15)) dutA (
    .clk(clk), .rst(rst), .enable(enA), .data_out(dataA), .valid_out(validA),
    .ready_in(rdyA), .done(doneA), .sent_count(cntA));

  tpg_source #(.ID(8'd5), .NODE(3), .DEST(15), .GAP(3), .NUM_PACKETS(4)) dutB (
    .clk(clk), .rst(rst), .enable(enB), .data_out(dataB), .valid_out(validB),
    .ready_in(rdyB), .done(doneB), .sent_count(cntB));

  tpg_source #(.ID(8'd5), .NODE(3), .DEST(1), .MODE(1), .NUM_PACKETS(20)) dutC (
    .clk(clk), .rst(rst), .enable(enC), .data_out(dataC), .valid_out(validC),
    .ready_in(rdyC), .done(doneC), .sent_count(cntC));

  tpg_source #(.NUM_PACKETS(0)) dutD (
    .clk(clk), .rst(rst), .enable(enD), .data_out(dataD), .valid_out(validD),
    .ready_in(rdyD), .done(doneD), .sent_count(cntD));

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] flitA(input int seq);
    return {4'd3, 4'd15, 8'd5, 16'(seq)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic y);
    rst  = r;
    enA  = e;
    rdyA = y;
  endtask

  task automatic applyReset();
    rst = 1'b0;
    enA = 0; enB = 0; enC = 0; enD = 0;
    rdyA = 0; rdyB = 0; rdyC = 0; rdyD = 0;
    stepCycle();
    stepCycle();
  endtask

  // Directed sequence of all scenarios.
  initial begin
    dstTab = '{1, 2, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 0, 1, 2, 4, 5, 6};
    patB   = 13'b1000100010001;

    // Reset state
    applyReset();
    checkOutput("rst_valid", 32'(validA), 32'd0);
    checkOutput("rst_done", 32'(doneA), 32'd0);
    checkOutput("rst_cnt", 32'(cntA), 32'd0);
    checkOutput("rst_data", dataA, 32'd0);
    checkOutput("rst_doneD", 32'(doneD), 32'd0);

    // Full back-to-back stream of 1002 flits
    applyStimulus(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 1002; i++) begin
      stepCycle();
      checkOutput("a_valid", 32'(validA), 32'd1);
      checkOutput("a_data", dataA, flitA(i));
      if (i == 1001) checkOutput("a_not_done_yet", 32'(doneA), 32'd0);
    end
    checkOutput("a_first_flit_const", flitA(0), 32'h3F05_0000);
    stepCycle();
    checkOutput("a_done", 32'(doneA), 32'd1);
    checkOutput("a_valid_done", 32'(validA), 32'd0);
    checkOutput("a_cnt_final", 32'(cntA), 32'd1002);
    enA = 1'b0;
    stepCycle();
    checkOutput("a_done_sticky", 32'(doneA), 32'd1);

    // Random backpressure
    applyReset();
    checkOutput("r_cnt_cleared", 32'(cntA), 32'd0);
    checkOutput("r_done_cleared", 32'(doneA), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    stepCycle();
    expSeq = 0;
    for (int k = 0; k < 80; k++) begin
      checkOutput("r_valid", 32'(validA), 32'd1);
      checkOutput("r_data", dataA, flitA(expSeq));
      hold = 1'($urandom_range(0, 1));
      rdyA = hold;
      stepCycle();
      if (hold) expSeq++;
    end
    checkOutput("r_cnt", 32'(cntA), 32'(expSeq));

    // Enable dropped while stalled: flit held, then IDLE after accept
    rdyA = 1'b0;
    enA  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      stepCycle();
      checkOutput("p_hold_valid", 32'(validA), 32'd1);
      checkOutput("p_hold_data", dataA, flitA(expSeq));
    end
    rdyA = 1'b1;
    stepCycle();
    checkOutput("p_idle_valid", 32'(validA), 32'd0);
    checkOutput("p_cnt", 32'(cntA), 32'(expSeq + 1));
    expSeq++;
    stepCycle();
    checkOutput("p_idle_valid2", 32'(validA), 32'd0);
    enA = 1'b1;
    stepCycle();
    checkOutput("p_resume_valid", 32'(validA), 32'd1);
    checkOutput("p_resume_data", dataA, flitA(expSeq));

    // Asynchronous reset mid-stream at seq 7
    applyReset();
    applyStimulus(1'b1, 1'b1, 1'b1);
    stepCycle();
    for (int k = 0; k < 7; k++) stepCycle();
    checkOutput("m_seq7", dataA, flitA(7));
    rst = 1'b0;
    #1;
    checkOutput("m_async_valid", 32'(validA), 32'd0);
    checkOutput("m_async_cnt", 32'(cntA), 32'd0);
    checkOutput("m_async_done", 32'(doneA), 32'd0);
    checkOutput("m_async_data", dataA, 32'd0);
    stepCycle();
    rst = 1'b1;
    stepCycle();
    checkOutput("m_restart_valid", 32'(validA), 32'd1);
    checkOutput("m_restart_data", dataA, flitA(0));

    // GAP=3, four packets
    applyReset();
    rst = 1'b1; enB = 1'b1; rdyB = 1'b1;
    for (int k = 0; k < 13; k++) begin
      stepCycle();
      checkOutput("g_valid", 32'(validB), 32'(patB[12-k]));
      if (k == 12) begin
        checkOutput("g_last_data", dataB, {4'd3, 4'd15, 8'd5, 16'd3});
        checkOutput("g_not_done", 32'(doneB), 32'd0);
      end
    end
    stepCycle();
    checkOutput("g_done", 32'(doneB), 32'd1);
    checkOutput("g_valid_done", 32'(validB), 32'd0);
    checkOutput("g_cnt", 32'(cntB), 32'd4);
    enB = 1'b0;
    stepCycle();
    checkOutput("g_done_sticky", 32'(doneB), 32'd1);

    // Rotating destinations skipping node 3
    applyReset();
    rst = 1'b1; enC = 1'b1; rdyC = 1'b1;
    for (int k = 0; k < 20; k++) begin
      stepCycle();
      checkOutput("c_dst", 32'(dataC[27:24]), 32'(dstTab[k]));
      checkOutput("c_seq", 32'(dataC[15:0]), 32'(k));
      checkOutput("c_src", 32'(dataC[31:28]), 32'd3);
    end
    stepCycle();
    checkOutput("c_done", 32'(doneC), 32'd1);

    // Zero packets: straight to done
    applyReset();
    rst = 1'b1; enD = 1'b1;
    stepCycle();
    checkOutput("d_done", 32'(doneD), 32'd1);
    checkOutput("d_valid", 32'(validD), 32'd0);
    checkOutput("d_cnt", 32'(cntD), 32'd0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
